// File: rtl/pc_next_unit_pkg.sv
// Shared types and constants for the program-counter / next-PC unit.
package pc_next_unit_pkg;

    localparam int WORD_W = 32;
    localparam int JIDX_W = 26;

    localparam logic [WORD_W-1:0] PC_INC = 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational candidate-target generation: sequential, branch and jump
// targets, plus detection of a JR target that is not word aligned.
module pc_target_calc
    import pc_next_unit_pkg::*;
(
    input  logic [WORD_W-1:0] pc,
    input  logic [WORD_W-1:0] branch_offset,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic [WORD_W-1:0] jr_target,
    output logic [WORD_W-1:0] pc_plus4,
    output logic [WORD_W-1:0] branch_tgt,
    output logic [WORD_W-1:0] jump_tgt,
    output logic              misalign
);

    // All sums wrap modulo 2^32; overflow is intentionally not detected.
    assign pc_plus4   = pc + PC_INC;
    assign branch_tgt = pc_plus4 + branch_offset;
    // Jumps stay inside the 256 MB region of the delay-slot address.
    assign jump_tgt   = {pc_plus4[WORD_W-1:WORD_W-4], jump_index, 2'b00};
    assign misalign   = |jr_target[1:0];

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter register and next-PC selection with stall, redirect
// flush and misaligned-JR halt.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal fetch; PC advances or is redirected (jr > jump > branch)
// HALT  | misaligned JR seen; PC frozen, fault high, left only by reset
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VECTOR     = 32'h0000_0000,
    parameter bit                HALT_ON_MISALIGN = 1'b1
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_offset,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic              jr,
    input  logic [WORD_W-1:0] jr_target,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4,
    output logic              flush,
    output logic              fault
);

    pc_state_t         state_q, state_nxt;
    logic [WORD_W-1:0] pc_q, pc_nxt;
    logic              flush_q, flush_nxt;
    logic              fault_q, fault_nxt;

    logic [WORD_W-1:0] branch_tgt;
    logic [WORD_W-1:0] jump_tgt;
    logic              misalign;

    pc_target_calc u_calc (
        .pc            (pc_q),
        .branch_offset (branch_offset),
        .jump_index    (jump_index),
        .jr_target     (jr_target),
        .pc_plus4      (pc_plus4),
        .branch_tgt    (branch_tgt),
        .jump_tgt      (jump_tgt),
        .misalign      (misalign)
    );

    // Next-state, next-PC and flag selection; stall masks every redirect.
    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        flush_nxt = 1'b0;
        unique case (state_q)
            RUN: begin
                if (!stall) begin
                    if (jr) begin
                        flush_nxt = 1'b1;
                        if (misalign && HALT_ON_MISALIGN) begin
                            state_nxt = HALT;
                        end else begin
                            pc_nxt = {jr_target[WORD_W-1:2], 2'b00};
                        end
                    end else if (jump) begin
                        pc_nxt    = jump_tgt;
                        flush_nxt = 1'b1;
                    end else if (branch_taken) begin
                        pc_nxt    = branch_tgt;
                        flush_nxt = 1'b1;
                    end else begin
                        pc_nxt = pc_plus4;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        fault_nxt = (state_nxt == HALT);
    end

    // State, PC and flag registers; reset wins over stall and HALT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_VECTOR;
            flush_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            flush_q <= flush_nxt;
            fault_q <= fault_nxt;
        end
    end

    assign pc    = pc_q;
    assign flush = flush_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios plus a
// randomized run against a behavioural next-PC model.
module tb_pc_next_unit;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump, jr;
    logic [31:0] branch_offset, jr_target;
    logic [25:0] jump_index;
    logic [31:0] pc, pc_plus4;
    logic        flush, fault;

    int checks   = 0;
    int failures = 0;

    // model state
    logic [31:0] m_pc;
    logic        m_halt;
    logic        m_flush;

    pc_next_unit #(
        .RESET_VECTOR     (RV),
        .HALT_ON_MISALIGN (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .flush         (flush),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    // Behavioural model of one rising edge, from the architectural rules.
    task automatic model_step();
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (reset) begin
            m_pc = RV; m_halt = 1'b0; m_flush = 1'b0;
        end else if (m_halt || stall) begin
            m_flush = 1'b0;
        end else if (jr) begin
            m_flush = 1'b1;
            if (jr_target % 4 != 0) m_halt = 1'b1;
            else m_pc = jr_target;
        end else if (jump) begin
            m_pc = (seq & 32'hF000_0000) + ({6'd0, jump_index} * 4);
            m_flush = 1'b1;
        end else if (branch_taken) begin
            m_pc = seq + branch_offset;
            m_flush = 1'b1;
        end else begin
            m_pc = seq;
            m_flush = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        branch_offset = '0; jump_index = '0; jr_target = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (pc !== RV || flush !== 1'b0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: pc=%h flush=%b fault=%b required pc=%h flush=0 fault=0", pc, flush, fault, RV);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (pc !== RV + 32'(4 * i) || flush !== 1'b0) begin
                failures++;
                $display("FAIL free_run_%0d: pc=%h flush=%b required pc=%h flush=0", i, pc, flush, RV + 32'(4 * i));
            end
        end
    endtask

    task automatic test_branch();
        idle_inputs();
        jr = 1'b1; jr_target = 32'h40;
        tick();
        idle_inputs();
        branch_taken = 1'b1; branch_offset = 32'hFFFF_FFF0;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h34 || flush !== 1'b1) begin
            failures++;
            $display("FAIL branch_neg: pc=%h flush=%b required pc=00000034 flush=1", pc, flush);
        end
        tick();
        checks++;
        if (pc !== 32'h38 || flush !== 1'b0) begin
            failures++;
            $display("FAIL branch_after: pc=%h flush=%b required pc=00000038 flush=0", pc, flush);
        end
    endtask

    task automatic test_jump();
        idle_inputs();
        jr = 1'b1; jr_target = 32'h1000_0010;
        tick();
        idle_inputs();
        jump = 1'b1; jump_index = 26'h100;
        branch_taken = 1'b1; branch_offset = 32'h0000_0100;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h1000_0400 || flush !== 1'b1) begin
            failures++;
            $display("FAIL jump_over_branch: pc=%h flush=%b required pc=10000400 flush=1", pc, flush);
        end
        // jr beats jump and branch
        jr = 1'b1; jr_target = 32'h0000_0800;
        jump = 1'b1; jump_index = 26'h3;
        branch_taken = 1'b1; branch_offset = 32'h40;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h800 || flush !== 1'b1) begin
            failures++;
            $display("FAIL jr_priority: pc=%h flush=%b required pc=00000800 flush=1", pc, flush);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        idle_inputs();
        held = pc;
        stall = 1'b1; jr = 1'b1; jr_target = 32'h200;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (pc !== held || flush !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold_%0d: pc=%h flush=%b required pc=%h flush=0", i, pc, flush, held);
            end
        end
        stall = 1'b0;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h200 || flush !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: pc=%h flush=%b required pc=00000200 flush=1", pc, flush);
        end
        tick();
        checks++;
        if (pc !== 32'h204 || flush !== 1'b0) begin
            failures++;
            $display("FAIL flush_single: pc=%h flush=%b required pc=00000204 flush=0", pc, flush);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] held;
        idle_inputs();
        held = pc;
        jr = 1'b1; jr_target = 32'h203;
        tick();
        idle_inputs();
        checks++;
        if (pc !== held || flush !== 1'b1 || fault !== 1'b1) begin
            failures++;
            $display("FAIL misalign_enter: pc=%h flush=%b fault=%b required pc=%h flush=1 fault=1", pc, flush, fault, held);
        end
        branch_taken = 1'b1; branch_offset = 32'h100;
        tick();
        jump = 1'b1; jump_index = 26'h55;
        jr = 1'b1; jr_target = 32'h300;
        tick();
        idle_inputs();
        checks++;
        if (pc !== held || flush !== 1'b0 || fault !== 1'b1) begin
            failures++;
            $display("FAIL halt_hold: pc=%h flush=%b fault=%b required pc=%h flush=0 fault=1", pc, flush, fault, held);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (pc !== RV || fault !== 1'b0 || flush !== 1'b0) begin
            failures++;
            $display("FAIL halt_reset: pc=%h flush=%b fault=%b required pc=%h flush=0 fault=0", pc, flush, fault, RV);
        end
    endtask

    task automatic test_wrap();
        idle_inputs();
        jr = 1'b1; jr_target = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        checks++;
        if (pc_plus4 !== 32'h0) begin
            failures++;
            $display("FAIL wrap_plus4: pc_plus4=%h required 00000000", pc_plus4);
        end
        tick();
        checks++;
        if (pc !== 32'h0) begin
            failures++;
            $display("FAIL wrap_seq: pc=%h required 00000000", pc);
        end
        // negative branch from pc=4 wraps below zero
        tick();
        branch_taken = 1'b1; branch_offset = 32'hFFFF_FFE0;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'hFFFF_FFE8) begin
            failures++;
            $display("FAIL wrap_branch: pc=%h required ffffffe8", pc);
        end
        stall = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (pc !== RV || flush !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_stall: pc=%h flush=%b required pc=%h flush=0", pc, flush, RV);
        end
    endtask

    task automatic test_random();
        idle_inputs();
        reset = 1'b1;
        tick();
        for (int n = 0; n < 400; n++) begin
            reset         = ($urandom_range(0, 39) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            jr            = ($urandom_range(0, 7) == 0);
            jump          = ($urandom_range(0, 7) == 0);
            branch_taken  = ($urandom_range(0, 3) == 0);
            branch_offset = $urandom & 32'hFFFF_FFFC;
            jump_index    = 26'($urandom);
            jr_target     = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) jr_target[1:0] = 2'($urandom_range(1, 3));
            tick();
            checks++;
            if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || flush !== m_flush || fault !== m_halt) begin
                failures++;
                $display("FAIL random_%0d: pc=%h p4=%h flush=%b fault=%b required pc=%h p4=%h flush=%b fault=%b",
                         n, pc, pc_plus4, flush, fault, m_pc, m_pc + 32'd4, m_flush, m_halt);
            end
        end
    endtask

    initial begin
        m_pc = RV; m_halt = 1'b0; m_flush = 1'b0;
        idle_inputs();
        #2;
        test_reset();
        test_branch();
        test_jump();
        test_stall();
        test_misalign();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter register and next-PC selection for the MIPS datapath.
- Consumes the word-aligned branch offset produced by the shift-left-2 stage and forms the branch target PC+4+offset.
- Also handles J/JAL and JR targets, pipeline stall and misaligned-target fault.
- Sits between the shift/decode logic and the instruction memory address port.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset. Must be word aligned.
- HALT_ON_MISALIGN, 1, 1 = enter HALT on a misaligned JR target; 0 = force the target low 2 bits to 00 and continue.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC; no update this cycle.
- branch_taken  input  1  conditional branch resolved taken.
- branch_offset  input  32  sign-extended immediate already shifted left by 2.
- jump  input  1  J/JAL.
- jump_index  input  26  instr[25:0].
- jr  input  1  JR/JALR.
- jr_target  input  32  rs register value.
- pc  output  32  current PC (registered), drives instruction memory.
- pc_plus4  output  32  pc + 4, combinational, for link register.
- flush  output  1  registered; high for exactly one cycle after any accepted redirect.
- fault  output  1  registered; high while in HALT.

Behaviour:
- Reset (synchronous, active-high) takes priority over everything:
  - pc = RESET_VECTOR, flush = 0, fault = 0, state = RUN.
  - This applies mid-stall or mid-HALT.
- Arithmetic (all 32-bit, wrap modulo 2^32, no overflow detection):
  - pc_plus4 = pc + 4.
  - branch_tgt = pc_plus4 + branch_offset.
  - jump_tgt = {pc_plus4[31:28], jump_index, 2'b00}.
- States:
  - RUN: normal operation.
  - HALT: PC frozen, fault = 1.
- RUN next-PC priority, evaluated at each rising edge:
  - stall = 1: pc holds; flush = 0; redirect inputs are ignored, and the upstream stage must hold them.
  - else jr = 1: pc = jr_target, flush = 1.
  - else jump = 1: pc = jump_tgt, flush = 1.
  - else branch_taken = 1: pc = branch_tgt, flush = 1.
  - else: pc = pc_plus4, flush = 0.
- Misaligned JR (jr = 1, not stalled, jr_target[1:0] != 0):
  - HALT_ON_MISALIGN = 1: pc holds, state goes to HALT, fault = 1 from the next cycle, flush = 1 for one cycle.
  - HALT_ON_MISALIGN = 0: pc = {jr_target[31:2], 2'b00}, flush = 1, stay in RUN.
- HALT:
  - All inputs are ignored; pc, fault = 1 and flush = 0 hold.
  - Exit only by reset.
- Simultaneous events:
  - jr, jump and branch_taken together: the highest priority wins (jr over jump over branch).
  - stall masks all of them.
- Latency: one cycle from redirect input to new pc; flush rises on that same edge.
- Boundary cases:
  - pc = 32'hFFFF_FFFC sequential → pc = 32'h0000_0000.
  - A negative offset wraps the same way.

Decomposition:
- Shared package: state encoding (RUN = 1'b0, HALT = 1'b1), PC_INC = 32'd4, and width constants for word address and jump index.
- One natural sub-module: pc_target_calc. It is combinational and produces pc_plus4, branch_tgt, jump_tgt and the misalign flag.
- The top level keeps the PC register, the FSM and the flush/fault flops.

Test Plan:
- Reset then 3 free-running cycles → pc = 0, 4, 8, 12; flush = 0 throughout.
- At pc = 0x40, branch_taken = 1, branch_offset = 0xFFFF_FFF0 → next pc = 0x34; flush = 1 for one cycle; pc = 0x38 after that.
- At pc = 0x1000_0010, jump = 1, jump_index = 0x0000_100 → pc = 0x1000_0400. Same cycle with branch_taken = 1 → jump still wins.
- stall = 1 for 2 cycles with jr = 1, jr_target = 0x200 → pc holds both cycles. stall drops → pc = 0x200, flush pulses once.
- jr_target = 0x203 with HALT_ON_MISALIGN = 1 → pc holds, fault = 1 and stays high. Later branch and jump inputs are ignored. reset → pc = RESET_VECTOR, fault = 0.
- Wrap check: force pc = 0xFFFF_FFFC, free-run → pc = 0x0. Assert reset during stall → pc = RESET_VECTOR on the next edge.
